mult_datapath: RTL and testbench

MULT_DATAPATH -- requirements
Module: mult_datapath

---
 rtl/mult_pkg.sv | 14 +
 rtl/iter_counter.sv | 29 ++
 rtl/mult_datapath.sv | 92 +++++++++
 tb/tb_mult_datapath.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier: default operand width,
// iteration counter width and product width.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = $clog2(MULT_WIDTH + 1);

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int MULT_PROD_W = prod_width(MULT_WIDTH);

endpackage

// File: rtl/iter_counter.sv
// Loadable down-counter that saturates at zero, with a zero flag taken
// straight from the register.
module iter_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // load wins over dec; dec at zero holds zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath driven step by step by an external control
// unit; one iteration is "latch lsb" followed by "add and shift".
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH-1:0]             multiplicand,
  input  logic [WIDTH-1:0]             multiplier,
  input  logic                         init,
  input  logic                         l_lsb,
  input  logic                         lsb_sel,
  input  logic                         shift_load,
  input  logic                         finish_cycle,
  output logic                         i_eq_0,
  output logic                         p_lsb,
  output logic [prod_width(WIDTH)-1:0] result,
  output logic                         result_valid
);

  localparam int PW = prod_width(WIDTH);

  logic [WIDTH-1:0] mcand_reg;
  logic [PW-1:0]    product_reg;
  logic             lsb_reg;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    shifted;

  assign addend  = (lsb_sel && lsb_reg) ? mcand_reg : '0;
  // Carry is kept so it lands in the top product bit after the shift
  assign sum     = {1'b0, product_reg[PW-1:WIDTH]} + {1'b0, addend};
  assign shifted = {sum, product_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg <= '0;
    end else if (init) begin
      mcand_reg <= multiplicand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product_reg <= '0;
    end else if (init) begin
      product_reg <= {{WIDTH{1'b0}}, multiplier};
    end else if (shift_load) begin
      product_reg <= shifted;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_reg <= 1'b0;
    end else if (init) begin
      lsb_reg <= 1'b0;
    end else if (l_lsb) begin
      lsb_reg <= product_reg[0];
    end
  end

  // result deliberately survives init so the last product stays readable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
    end else if (init) begin
      result_valid <= 1'b0;
    end else if (finish_cycle) begin
      result       <= product_reg;
      result_valid <= 1'b1;
    end
  end

  iter_counter #(
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (init),
    .load_val (CNT_W'(WIDTH)),
    .dec      (shift_load && !init),
    .zero     (i_eq_0)
  );

  assign p_lsb = product_reg[0];

endmodule

// File: tb/tb_mult_datapath.sv
// Scoreboard bench for mult_datapath: expected products are queued at init
// and compared when result_valid is observed.
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int W  = MULT_WIDTH;
  localparam int PW = MULT_PROD_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  multiplicand = '0;
  logic [W-1:0]  multiplier = '0;
  logic          init = 1'b0;
  logic          l_lsb = 1'b0;
  logic          lsb_sel = 1'b0;
  logic          shift_load = 1'b0;
  logic          finish_cycle = 1'b0;
  logic          i_eq_0;
  logic          p_lsb;
  logic [PW-1:0] result;
  logic          result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];

  mult_datapath #(.WIDTH(W), .CNT_W(MULT_CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .init         (init),
    .l_lsb        (l_lsb),
    .lsb_sel      (lsb_sel),
    .shift_load   (shift_load),
    .finish_cycle (finish_cycle),
    .i_eq_0       (i_eq_0),
    .p_lsb        (p_lsb),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // one clock with the given controls, outputs sampled 1 time unit after the edge
  task automatic cyc(input bit c_init, input bit c_llsb, input bit c_sel,
                     input bit c_shift, input bit c_fin);
    init = c_init; l_lsb = c_llsb; lsb_sel = c_sel;
    shift_load = c_shift; finish_cycle = c_fin;
    @(posedge clk);
    #1;
    init = 1'b0; l_lsb = 1'b0; lsb_sel = 1'b0;
    shift_load = 1'b0; finish_cycle = 1'b0;
  endtask

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    multiplicand = a;
    multiplier   = b;
    exp_q.push_back(PW'(a) * PW'(b));
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic iterate(input int n, input bit chk_cnt, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
      if (chk_cnt && (i == W - 2 || i == W - 1))
        check_eq({tag, "_i_eq_0"}, PW'(i_eq_0), PW'(i == W - 1));
    end
  endtask

  task automatic finish_and_check(input string tag);
    logic [PW-1:0] expv;
    int waited;
    cyc(0, 0, 0, 0, 1);
    waited = 0;
    while (!result_valid && waited < 8) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq({tag, "_valid"}, PW'(result_valid), PW'(1));
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue"}, PW'(0), PW'(1));
    end else begin
      expv = exp_q.pop_front();
      check_eq({tag, "_result"}, result, expv);
      $display("txn %s: result=%h expected=%h", tag, result, expv);
    end
  endtask

  task automatic full_run(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    start(a, b);
    check_eq({tag, "_valid_cleared"}, PW'(result_valid), PW'(0));
    check_eq({tag, "_i_eq_0_after_init"}, PW'(i_eq_0), PW'(0));
    iterate(W, 1'b1, tag);
    finish_and_check(tag);
  endtask

  initial begin
    logic [PW-1:0] held;

    // reset state, sampled while reset is asserted
    #3;
    check_eq("rst_result", result, '0);
    check_eq("rst_valid", PW'(result_valid), PW'(0));
    check_eq("rst_i_eq_0", PW'(i_eq_0), PW'(1));
    check_eq("rst_p_lsb", PW'(p_lsb), PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_i_eq_0", PW'(i_eq_0), PW'(1));

    full_run(32'd3, 32'd5, "3x5");

    // init does not disturb the held result
    held = result;
    start(32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("init_keeps_result", result, held);
    iterate(W, 1'b1, "ffxff");
    finish_and_check("ffxff");

    full_run(32'd0, 32'h12345678, "0xB");
    full_run(32'h12345678, 32'd0, "Ax0");
    full_run(32'hDEADBEEF, 32'h0BADF00D, "mixed");
    full_run($urandom, $urandom, "rand");

    // extra shift at count 0: saturates, product shifts once
    full_run(32'd3, 32'd5, "3x5b");
    exp_q.push_back(PW'(15) >> 1);
    cyc(0, 0, 0, 1, 0);
    check_eq("sat_i_eq_0", PW'(i_eq_0), PW'(1));
    check_eq("sat_p_lsb", PW'(p_lsb), PW'(1));
    finish_and_check("sat_shift");

    // all-zero controls hold everything
    held = result;
    repeat (3) cyc(0, 0, 0, 0, 0);
    check_eq("hold_result", result, held);
    check_eq("hold_valid", PW'(result_valid), PW'(1));

    // init with shift_load in the same cycle: no shift, counter reloaded
    multiplicand = 32'h11111111;
    multiplier   = 32'h80000003;
    exp_q.push_back({{W{1'b0}}, 32'h80000003});
    cyc(1, 1, 1, 1, 0);
    check_eq("init_shift_i_eq_0", PW'(i_eq_0), PW'(0));
    check_eq("init_shift_p_lsb", PW'(p_lsb), PW'(1));
    finish_and_check("init_shift");

    // asynchronous reset after 10 iterations, between clock edges
    start(32'hCAFEF00D, 32'h00001235);
    void'(exp_q.pop_back());
    iterate(10, 1'b0, "abort");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_result", result, '0);
    check_eq("async_rst_valid", PW'(result_valid), PW'(0));
    check_eq("async_rst_i_eq_0", PW'(i_eq_0), PW'(1));
    check_eq("async_rst_p_lsb", PW'(p_lsb), PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_abort_valid", PW'(result_valid), PW'(0));

    full_run(32'd7, 32'd9, "7x9");
    check_eq("7x9_literal", result, PW'(63));
    check_eq("queue_drained", PW'(exp_q.size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
